fp16_exponent_align: RTL and testbench

//  Exponent-compare and mantissa-alignment stage of the half-precision adder/subtractor.
//  - Orders two operands by magnitude.
//  - Forms the exponent difference as e_big + ~e_small + 1 (two's-complement subtract).
//  - Right-shifts the smaller significand one bit per cycle, keeping guard/round/sticky bits.
//  - Feeds the significand adder; valid/ready handshake on both sides.

---
 rtl/fp16_exponent_align.sv | 264 ++++++++++++++++++++++++++
 tb/tb_fp16_exponent_align.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_exponent_align.sv
`default_nettype none
// ============================================================================
// Module   : fp16_exponent_align
// Purpose  : Exponent-compare and significand-alignment stage of the
//            half-precision adder/subtractor. Orders the operand pair by
//            magnitude and forms the exponent difference. It then shifts the
//            smaller significand right one bit per cycle, keeping
//            guard/round/sticky bits, for the significand adder downstream.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1          rising-edge clock
//   rst_n       in   1          asynchronous, active-low reset
//   in_valid    in   1          operand pair valid
//   in_ready    out  1          block can accept (IDLE only)
//   a, b        in   1+E+M      operands {sign, exp, frac}
//   op_sub      in   1          1 = a-b, 0 = a+b
//   out_valid   out  1          aligned result valid (DONE only)
//   out_ready   in   1          downstream accepts
//   swap        out  1          b is the larger-magnitude operand
//   eff_sub     out  1          effective subtraction
//   sign_big    out  1          sign of the larger operand (after op_sub)
//   exp_big     out  E          effective exponent of the larger operand
//   mant_big    out  M+1        {hidden, frac} of the larger operand
//   mant_small  out  M+4        aligned {hidden, frac, G, R, S} of smaller
//   special     out  1          either exponent is all ones (Inf/NaN)
// ============================================================================
module fp16_exponent_align #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   op_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   swap,
    output logic                   eff_sub,
    output logic                   sign_big,
    output logic [EXP_W-1:0]       exp_big,
    output logic [MAN_W:0]         mant_big,
    output logic [MAN_W+3:0]       mant_small,
    output logic                   special
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int                 c_op_w     = 1 + EXP_W + MAN_W;
    localparam int                 c_vec_w    = MAN_W + 4;
    localparam int                 c_key_w    = EXP_W + 1 + MAN_W;
    // Shifts of this size or more push every bit into sticky.
    localparam logic [EXP_W-1:0]   c_collapse = EXP_W'(c_vec_w);
    localparam logic [EXP_W-1:0]   c_exp_one  = EXP_W'(1);
    localparam logic [EXP_W-1:0]   c_exp_max  = {EXP_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_SHIFT   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_q,     state_d;
    logic                 in_ready_q,  in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [c_op_w-1:0]    a_q,         a_d;
    logic [c_op_w-1:0]    b_q,         b_d;
    logic                 op_sub_q,    op_sub_d;
    logic [EXP_W-1:0]     cnt_q,       cnt_d;
    logic [c_vec_w-1:0]   vec_q,       vec_d;
    logic                 swap_q,      swap_d;
    logic                 eff_sub_q,   eff_sub_d;
    logic                 sign_big_q,  sign_big_d;
    logic [EXP_W-1:0]     exp_big_q,   exp_big_d;
    logic [MAN_W:0]       mant_big_q,  mant_big_d;
    logic                 special_q,   special_d;

    // ------------------------------------------------------------------
    // Operand unpack (from the captured operands)
    // ------------------------------------------------------------------
    logic                 w_sign_a,    w_sign_b;
    logic [EXP_W-1:0]     w_exp_a,     w_exp_b;
    logic [MAN_W-1:0]     w_frac_a,    w_frac_b;
    logic                 w_hid_a,     w_hid_b;
    logic [EXP_W-1:0]     w_eexp_a,    w_eexp_b;
    logic [c_key_w-1:0]   w_key_a,     w_key_b;

    assign w_sign_a = a_q[c_op_w-1];
    assign w_sign_b = b_q[c_op_w-1];
    assign w_exp_a  = a_q[MAN_W +: EXP_W];
    assign w_exp_b  = b_q[MAN_W +: EXP_W];
    assign w_frac_a = a_q[MAN_W-1:0];
    assign w_frac_b = b_q[MAN_W-1:0];

    // Subnormals have no hidden one and use exponent 1.
    assign w_hid_a  = (w_exp_a != '0);
    assign w_hid_b  = (w_exp_b != '0);
    assign w_eexp_a = w_hid_a ? w_exp_a : c_exp_one;
    assign w_eexp_b = w_hid_b ? w_exp_b : c_exp_one;

    assign w_key_a  = {w_eexp_a, w_hid_a, w_frac_a};
    assign w_key_b  = {w_eexp_b, w_hid_b, w_frac_b};

    // ------------------------------------------------------------------
    // Compare, exponent difference and initial alignment vector
    // ------------------------------------------------------------------
    logic                 w_b_big;
    logic [EXP_W-1:0]     w_exp_big,   w_exp_small;
    logic                 w_hid_big,   w_hid_small;
    logic [MAN_W-1:0]     w_frac_big,  w_frac_small;
    logic [EXP_W-1:0]     w_diff;
    logic                 w_collapse;
    logic [c_vec_w-1:0]   w_vec_raw;
    logic [c_vec_w-1:0]   w_vec_init;
    logic [EXP_W-1:0]     w_cnt_init;
    logic [c_vec_w-1:0]   w_vec_shift;

    // Equal magnitudes keep a as the big operand.
    assign w_b_big      = (w_key_b > w_key_a);

    assign w_exp_big    = w_b_big ? w_eexp_b : w_eexp_a;
    assign w_exp_small  = w_b_big ? w_eexp_a : w_eexp_b;
    assign w_hid_big    = w_b_big ? w_hid_b  : w_hid_a;
    assign w_hid_small  = w_b_big ? w_hid_a  : w_hid_b;
    assign w_frac_big   = w_b_big ? w_frac_b : w_frac_a;
    assign w_frac_small = w_b_big ? w_frac_a : w_frac_b;

    // Two's-complement subtract; never negative because of the ordering.
    assign w_diff       = w_exp_big + ~w_exp_small + c_exp_one;
    assign w_collapse   = (w_diff >= c_collapse);

    assign w_vec_raw    = {w_hid_small, w_frac_small, 3'b000};
    assign w_vec_init   = w_collapse ? {{(c_vec_w-1){1'b0}}, |w_vec_raw}
                                     : w_vec_raw;
    assign w_cnt_init   = w_collapse ? '0 : w_diff;

    // One-bit right shift; the bit leaving position 1 folds into sticky.
    assign w_vec_shift  = {1'b0, vec_q[c_vec_w-1:2], vec_q[1] | vec_q[0]};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_sub_d   = op_sub_q;
        cnt_d      = cnt_q;
        vec_d      = vec_q;
        swap_d     = swap_q;
        eff_sub_d  = eff_sub_q;
        sign_big_d = sign_big_q;
        exp_big_d  = exp_big_q;
        mant_big_d = mant_big_q;
        special_d  = special_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    op_sub_d = op_sub;
                    state_d  = S_COMPARE;
                end
            end

            S_COMPARE: begin
                swap_d     = w_b_big;
                eff_sub_d  = w_sign_a ^ w_sign_b ^ op_sub_q;
                // The subtrahend's sign flips when it is the big operand.
                sign_big_d = w_b_big ? (w_sign_b ^ op_sub_q) : w_sign_a;
                exp_big_d  = w_exp_big;
                mant_big_d = {w_hid_big, w_frac_big};
                special_d  = (w_exp_a == c_exp_max) || (w_exp_b == c_exp_max);
                vec_d      = w_vec_init;
                cnt_d      = w_cnt_init;
                state_d    = (w_cnt_init == '0) ? S_DONE : S_SHIFT;
            end

            S_SHIFT: begin
                vec_d = w_vec_shift;
                cnt_d = cnt_q - c_exp_one;
                if (cnt_q == c_exp_one) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // Handshake returns to IDLE only; acceptance waits a cycle.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake flags are registered copies of the next state.
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_sub_q    <= 1'b0;
            cnt_q       <= '0;
            vec_q       <= '0;
            swap_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            sign_big_q  <= 1'b0;
            exp_big_q   <= '0;
            mant_big_q  <= '0;
            special_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_sub_q    <= op_sub_d;
            cnt_q       <= cnt_d;
            vec_q       <= vec_d;
            swap_q      <= swap_d;
            eff_sub_q   <= eff_sub_d;
            sign_big_q  <= sign_big_d;
            exp_big_q   <= exp_big_d;
            mant_big_q  <= mant_big_d;
            special_q   <= special_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign swap       = swap_q;
    assign eff_sub    = eff_sub_q;
    assign sign_big   = sign_big_q;
    assign exp_big    = exp_big_q;
    assign mant_big   = mant_big_q;
    assign mant_small = vec_q;
    assign special    = special_q;

endmodule
`default_nettype wire

// File: tb/tb_fp16_exponent_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fp16_exponent_align
// Purpose  : Self-checking bench for fp16_exponent_align. A vector table of
//            operand pairs with expected aligned outputs and latency, run
//            through a scoreboard queue. Hand sequences cover output
//            back-pressure and an asynchronous reset in the middle of a shift.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp16_exponent_align;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        op_sub;
        logic        swap;
        logic        eff_sub;
        logic        sign_big;
        logic [4:0]  exp_big;
        logic [10:0] mant_big;
        logic [13:0] mant_small;
        logic        special;
        int          lat;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic        swap;
    logic        eff_sub;
    logic        sign_big;
    logic [4:0]  exp_big;
    logic [10:0] mant_big;
    logic [13:0] mant_small;
    logic        special;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    sb_t  sb[$];
    vec_t tbl[10];

    fp16_exponent_align #(
        .EXP_W (5),
        .MAN_W (10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op_sub     (op_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .swap       (swap),
        .eff_sub    (eff_sub),
        .sign_big   (sign_big),
        .exp_big    (exp_big),
        .mant_big   (mant_big),
        .mant_small (mant_small),
        .special    (special)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge
    // after the accept edge.
    task automatic drive_accept(input vec_t v);
        a        = v.a;
        b        = v.b;
        op_sub   = v.op_sub;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        sb.push_back('{v, cyc});
        check("in_ready_busy", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic wait_result();
        int  n;
        sb_t e;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL timeout: out_valid=0 after %0d cycles, expected 1", n);
            return;
        end
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: queue size 0, expected 1");
            return;
        end
        e = sb.pop_front();
        check("swap",       {31'd0, swap},        {31'd0, e.v.swap});
        check("eff_sub",    {31'd0, eff_sub},     {31'd0, e.v.eff_sub});
        check("sign_big",   {31'd0, sign_big},    {31'd0, e.v.sign_big});
        check("exp_big",    {27'd0, exp_big},     {27'd0, e.v.exp_big});
        check("mant_big",   {21'd0, mant_big},    {21'd0, e.v.mant_big});
        check("mant_small", {18'd0, mant_small},  {18'd0, e.v.mant_small});
        check("special",    {31'd0, special},     {31'd0, e.v.special});
        check("latency",    32'(cyc - e.acc),     32'(e.v.lat));
        check("in_ready_done", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_hs",  {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        //          a        b        op    swp   esub  sgn   exp     mant_big  mant_small spec  lat
        tbl[0] = '{16'h3C00, 16'h3800, 1'b0, 1'b0, 1'b0, 1'b0, 5'd15, 11'h400, 14'h1000, 1'b0, 2};
        tbl[1] = '{16'h3C00, 16'hBE00, 1'b0, 1'b1, 1'b1, 1'b1, 5'd15, 11'h600, 14'h2000, 1'b0, 1};
        tbl[2] = '{16'h7800, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 5'd30, 11'h400, 14'h0001, 1'b0, 1};
        tbl[3] = '{16'h4C00, 16'h3C01, 1'b0, 1'b0, 1'b0, 1'b0, 5'd19, 11'h400, 14'h0201, 1'b0, 5};
        tbl[4] = '{16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1,  11'h002, 14'h0008, 1'b0, 1};
        tbl[5] = '{16'h7C00, 16'h3C00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd31, 11'h400, 14'h0001, 1'b1, 1};
        tbl[6] = '{16'h3C00, 16'hBC00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd15, 11'h400, 14'h2000, 1'b0, 1};
        tbl[7] = '{16'h7000, 16'h3C00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd28, 11'h400, 14'h0001, 1'b0, 14};
        tbl[8] = '{16'h3800, 16'h4000, 1'b1, 1'b1, 1'b1, 1'b1, 5'd16, 11'h400, 14'h0800, 1'b0, 3};
        tbl[9] = '{16'hC400, 16'h3C00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd17, 11'h400, 14'h0800, 1'b0, 3};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op_sub    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_in_ready",   {31'd0, in_ready},   32'd1);
        check("rst_out_valid",  {31'd0, out_valid},  32'd0);
        check("rst_mant_small", {18'd0, mant_small}, 32'd0);
        check("rst_exp_big",    {27'd0, exp_big},    32'd0);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            drive_accept(tbl[i]);
            wait_result();
            handshake();
        end

        // Back-pressure: out_ready low for 3 cycles with a new op pending.
        drive_accept(tbl[0]);
        wait_result();
        a        = tbl[1].a;
        b        = tbl[1].b;
        op_sub   = tbl[1].op_sub;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_out_valid",  {31'd0, out_valid},  32'd1);
            check("hold_in_ready",   {31'd0, in_ready},   32'd0);
            check("hold_mant_small", {18'd0, mant_small}, 32'h1000);
            check("hold_exp_big",    {27'd0, exp_big},    32'd15);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        // Back in IDLE with in_valid still high: not accepted on the same edge.
        check("hs_out_valid", {31'd0, out_valid}, 32'd0);
        check("hs_in_ready",  {31'd0, in_ready},  32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        sb.push_back('{tbl[1], cyc});
        check("next_accepted", {31'd0, in_ready}, 32'd0);
        wait_result();
        handshake();

        // Asynchronous reset in the middle of a shift.
        drive_accept(tbl[3]);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid",  {31'd0, out_valid},  32'd0);
        check("arst_in_ready",   {31'd0, in_ready},   32'd1);
        check("arst_mant_small", {18'd0, mant_small}, 32'd0);
        check("arst_exp_big",    {27'd0, exp_big},    32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_accept(tbl[0]);
        wait_result();
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
